// File: rtl/cms_axis_trace_receiver.sv
// AXI-Stream receive end for continuous_monitoring_system trace beats.
// Buffers beats in a FIFO, unpacks them into an item port, checks tlast spacing and keeps statistics.
module cms_axis_trace_receiver #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned XLEN           = 64,
  parameter int unsigned AXI_DATA_WIDTH = 512
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             S_AXIS_tvalid,
  output logic                             S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0]        S_AXIS_tdata,
  input  logic                             S_AXIS_tlast,
  input  logic [31:0]                      tlast_interval,
  input  logic                             en,
  output logic                             item_valid,
  input  logic                             item_ready,
  output logic [XLEN-1:0]                  item_pc,
  output logic [31:0]                      item_instr,
  output logic [AXI_DATA_WIDTH-XLEN-33:0]  item_payload,
  output logic                             item_last,
  output logic [31:0]                      beat_count,
  output logic [31:0]                      packet_count,
  output logic                             early_tlast_err,
  output logic                             missing_tlast_err,
  input  logic                             error_clear
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PAY_W = AXI_DATA_WIDTH - XLEN - 32;

  logic [AXI_DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     mem_last;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          fifo_count;
  logic [31:0]               beat_idx;

  logic                      push;
  logic                      pop;
  logic [AXI_DATA_WIDTH-1:0] head_data;
  logic [31:0]               pos;
  logic [31:0]               beat_idx_nxt;
  logic                      early_set;
  logic                      missing_set;

  // Handshake decode from registered occupancy only; tready never looks at tvalid.
  assign S_AXIS_tready = en & (fifo_count < CNT_W'(FIFO_DEPTH));
  assign item_valid    = (fifo_count != '0);
  assign push          = S_AXIS_tvalid & S_AXIS_tready;
  assign pop           = item_valid & item_ready;

  assign head_data     = mem_data[rd_ptr];
  assign item_pc       = head_data[XLEN-1:0];
  assign item_instr    = head_data[XLEN+31:XLEN];
  assign item_payload  = head_data[AXI_DATA_WIDTH-1:XLEN+32];
  assign item_last     = mem_last[rd_ptr];

  // Beat storage; cleared on reset so the item outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_data[i] <= '0;
      end
      mem_last <= '0;
    end else if (push) begin
      mem_data[wr_ptr] <= S_AXIS_tdata;
      mem_last[wr_ptr] <= S_AXIS_tlast;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count   <= '0;
      packet_count <= '0;
    end else if (push) begin
      beat_count <= beat_count + 32'd1;
      if (S_AXIS_tlast) packet_count <= packet_count + 32'd1;
    end
  end

  // Packet-length checker: position of the incoming beat against the expected interval.
  always_comb begin
    pos          = beat_idx + 32'd1;
    beat_idx_nxt = beat_idx;
    early_set    = 1'b0;
    missing_set  = 1'b0;
    if (push) begin
      if (tlast_interval == 32'd0) begin
        beat_idx_nxt = S_AXIS_tlast ? 32'd0 : pos;
      end else if (S_AXIS_tlast && (pos < tlast_interval)) begin
        early_set    = 1'b1;
        beat_idx_nxt = 32'd0;
      end else if (!S_AXIS_tlast && (pos >= tlast_interval)) begin
        missing_set  = 1'b1;
        beat_idx_nxt = 32'd0;
      end else if (S_AXIS_tlast && (pos == tlast_interval)) begin
        beat_idx_nxt = 32'd0;
      end else begin
        beat_idx_nxt = pos;
      end
    end
  end

  // Sticky flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx          <= '0;
      early_tlast_err   <= 1'b0;
      missing_tlast_err <= 1'b0;
    end else begin
      beat_idx <= beat_idx_nxt;
      if (early_set)        early_tlast_err <= 1'b1;
      else if (error_clear) early_tlast_err <= 1'b0;
      if (missing_set)        missing_tlast_err <= 1'b1;
      else if (error_clear)   missing_tlast_err <= 1'b0;
    end
  end

  logic unused_pay;
  assign unused_pay = (PAY_W == 0);

endmodule

// File: tb/tb_cms_axis_trace_receiver.sv
// Self-checking bench for cms_axis_trace_receiver: scoreboard on the item port plus
// table-driven tlast checker vectors and hand-written corner sequences.
module tb_cms_axis_trace_receiver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XL    = 64;
  localparam int unsigned DW    = 512;
  localparam int unsigned PW    = DW - XL - 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            s_tvalid;
  logic            s_tready;
  logic [DW-1:0]   s_tdata;
  logic            s_tlast;
  logic [31:0]     interval;
  logic            en;
  logic            item_valid;
  logic            item_ready;
  logic [XL-1:0]   item_pc;
  logic [31:0]     item_instr;
  logic [PW-1:0]   item_payload;
  logic            item_last;
  logic [31:0]     beat_count;
  logic [31:0]     packet_count;
  logic            early_err;
  logic            missing_err;
  logic            error_clear;

  cms_axis_trace_receiver #(.FIFO_DEPTH(DEPTH), .XLEN(XL), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready), .S_AXIS_tdata(s_tdata),
    .S_AXIS_tlast(s_tlast), .tlast_interval(interval), .en(en),
    .item_valid(item_valid), .item_ready(item_ready), .item_pc(item_pc),
    .item_instr(item_instr), .item_payload(item_payload), .item_last(item_last),
    .beat_count(beat_count), .packet_count(packet_count),
    .early_tlast_err(early_err), .missing_tlast_err(missing_err),
    .error_clear(error_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] ivl;
    logic        last;
    logic        clr;
    logic        exp_early;
    logic        exp_missing;
    logic [31:0] exp_pkt;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   mcount = 0;
  vec_t vt[19];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [63:0] pc, input logic [31:0] ins);
    logic [31:0] w;
    w = pc[31:0] ^ 32'hA5A5_0000;
    return {{13{w}}, ins, pc};
  endfunction

  // Scoreboard: push on accept, pop and compare on item handshake; track occupancy.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcount = 0;
    end else begin
      logic acc;
      logic pp;
      exp_t e;
      chk("tready", DW'(s_tready), DW'(en && (mcount < int'(DEPTH))));
      chk("item_valid", DW'(item_valid), DW'(mcount != 0));
      acc = s_tvalid && s_tready;
      pp  = item_valid && item_ready;
      if (acc) q.push_back({s_tlast, s_tdata});
      if (pp) begin
        if (q.size() == 0) begin
          chk("unexpected_item", DW'(item_pc), '1);
        end else begin
          e = q.pop_front();
          chk("item_pc", DW'(item_pc), DW'(e.data[XL-1:0]));
          chk("item_instr", DW'(item_instr), DW'(e.data[XL+31:XL]));
          chk("item_payload", DW'(item_payload), DW'(e.data[DW-1:XL+32]));
          chk("item_last", DW'(item_last), DW'(e.last));
        end
      end
      mcount = mcount + int'(acc) - int'(pp);
    end
  end

  task automatic send_beat(input logic [63:0] pc, input logic [31:0] ins, input logic last);
    int  n;
    logic ok;
    n = 0;
    ok = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = mk(pc, ins);
    s_tlast  = last;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("accept_timeout", DW'(0), DW'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[1]  = '{32'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1};
    vt[2]  = '{32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
    vt[3]  = '{32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
    vt[4]  = '{32'd4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
    vt[5]  = '{32'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'd2};
    vt[6]  = '{32'd4, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2};
    vt[7]  = '{32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2};
    vt[8]  = '{32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2};
    vt[9]  = '{32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
    vt[10] = '{32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3};
    vt[11] = '{32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3};
    vt[12] = '{32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3};
    vt[13] = '{32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3};
    vt[14] = '{32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3};
    vt[15] = '{32'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3};
    vt[16] = '{32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3};
    vt[17] = '{32'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4};
    vt[18] = '{32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd5};

    rst_n = 1'b0; en = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    interval = 32'd4; item_ready = 1'b0; error_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_item_valid", DW'(item_valid), DW'(0));
    chk("rst_tready", DW'(s_tready), DW'(0));
    chk("rst_beat_count", DW'(beat_count), DW'(0));
    chk("rst_packet_count", DW'(packet_count), DW'(0));
    chk("rst_early", DW'(early_err), DW'(0));
    chk("rst_missing", DW'(missing_err), DW'(0));
    chk("rst_item_pc", DW'(item_pc), DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b1;

    // Back-to-back packets of four, consumer always ready.
    item_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(64'h1000 + 64'(i), 32'h13 + 32'(i), (i == 3) || (i == 7));
    idle(3);
    chk("t1_beat_count", DW'(beat_count), DW'(8));
    chk("t1_packet_count", DW'(packet_count), DW'(2));
    chk("t1_early", DW'(early_err), DW'(0));
    chk("t1_missing", DW'(missing_err), DW'(0));

    // Fill to full, then a single pop admits the held beat one cycle later.
    item_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(64'h3000 + 64'(i), 32'h40 + 32'(i), i == 3);
    s_tvalid = 1'b1;
    s_tdata  = mk(64'h3004, 32'h44);
    s_tlast  = 1'b0;
    @(negedge clk);
    chk("t2_full_tready", DW'(s_tready), DW'(0));
    @(posedge clk); #1;
    item_ready = 1'b1;
    @(negedge clk);
    chk("t2_pop_cycle_tready", DW'(s_tready), DW'(0));
    @(posedge clk); #1;
    item_ready = 1'b0;
    @(negedge clk);
    chk("t2_after_pop_tready", DW'(s_tready), DW'(1));
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    chk("t2_beat_count", DW'(beat_count), DW'(13));
    item_ready = 1'b1;
    idle(6);
    chk("t2_drained", DW'(item_valid), DW'(0));
    do_reset();

    // tlast checker vectors: each row is one accepted beat.
    for (int i = 0; i < 19; i++) begin
      interval = vt[i].ivl;
      error_clear = vt[i].clr;
      send_beat(64'h2000 + 64'(i), 32'h77 + 32'(i), vt[i].last);
      error_clear = 1'b0;
      chk($sformatf("vec%0d_early", i), DW'(early_err), DW'(vt[i].exp_early));
      chk($sformatf("vec%0d_missing", i), DW'(missing_err), DW'(vt[i].exp_missing));
      chk($sformatf("vec%0d_pkt", i), DW'(packet_count), DW'(vt[i].exp_pkt));
    end
    idle(2);

    // Three buffered, disable accept, drain partly, async reset between edges.
    item_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(64'h5000 + 64'(i), 32'h90 + 32'(i), 1'b0);
    en = 1'b0;
    #1;
    chk("t5_tready_en0", DW'(s_tready), DW'(0));
    item_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_mid_drain_valid", DW'(item_valid), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_arst_item_valid", DW'(item_valid), DW'(0));
    chk("t5_arst_beat_count", DW'(beat_count), DW'(0));
    chk("t5_arst_packet_count", DW'(packet_count), DW'(0));
    chk("t5_arst_early", DW'(early_err), DW'(0));
    chk("t5_arst_missing", DW'(missing_err), DW'(0));
    chk("t5_arst_item_pc", DW'(item_pc), DW'(0));
    chk("t5_arst_item_last", DW'(item_last), DW'(0));
    idle(2);

    // beat_count wrap from a preloaded value.
    rst_n = 1'b1;
    en = 1'b1;
    interval = 32'd0;
    item_ready = 1'b1;
    force dut.beat_count = 32'hFFFF_FFFE;
    #2;
    release dut.beat_count;
    chk("t6_preload", DW'(beat_count), DW'(32'hFFFF_FFFE));
    for (int i = 0; i < 3; i++) send_beat(64'h6000 + 64'(i), 32'hA0 + 32'(i), 1'b0);
    chk("t6_wrap", DW'(beat_count), DW'(32'h0000_0001));
    chk("t6_packet_count", DW'(packet_count), DW'(0));
    idle(3);
    chk("sb_empty", DW'(q.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cms_axis_trace_receiver.md
Name: cms_axis_trace_receiver

Overview:
AXI-Stream slave that consumes the 512-bit trace beats produced by continuous_monitoring_system on its M_AXIS port. It is the receive end of that stream, used in simulation and on-chip loopback/self-test paths.
- Buffers beats in a small FIFO and unpacks each beat into pc/instr/payload fields behind a valid/ready item port.
- Checks that tlast arrives every tlast_interval beats.
- Keeps beat, packet and error statistics.

Parameters:
- FIFO_DEPTH, 4, number of beats buffered; power of two, minimum 2.
- XLEN, 64, width of the pc field.
- AXI_DATA_WIDTH, 512, width of S_AXIS_tdata.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- S_AXIS_tvalid  input  1  beat valid from the trace source.
- S_AXIS_tready  output  1  receiver can accept a beat.
- S_AXIS_tdata  input  AXI_DATA_WIDTH  trace beat.
- S_AXIS_tlast  input  1  last beat of the packet.
- tlast_interval  input  32  expected beats per packet; 0 disables checking.
- en  input  1  accept enable; 0 forces tready low.
- item_valid  output  1  unpacked item available.
- item_ready  input  1  consumer accepts the item.
- item_pc  output  XLEN  tdata[XLEN-1:0] of the head beat.
- item_instr  output  32  tdata[XLEN+31:XLEN] of the head beat.
- item_payload  output  AXI_DATA_WIDTH-XLEN-32  remaining upper bits of the head beat.
- item_last  output  1  tlast stored with the head beat.
- beat_count  output  32  total beats accepted; wraps.
- packet_count  output  32  total tlast beats accepted; wraps.
- early_tlast_err  output  1  sticky flag: tlast arrived before tlast_interval beats.
- missing_tlast_err  output  1  sticky flag: beat number tlast_interval arrived without tlast.
- error_clear  input  1  clears both sticky error flags.

Behaviour:
Reset values:
- All outputs 0; FIFO empty; internal beat index 0.
- Reset is asynchronous and may assert mid-packet or mid-FIFO. All state is discarded with no partial completion.

Handshake:
- S_AXIS_tready = en & (fifo_count < FIFO_DEPTH), decoded combinationally from registered count. It does not depend on S_AXIS_tvalid.
- Accept = S_AXIS_tvalid & S_AXIS_tready. tdata and tlast are written at that edge.
- item_valid = (fifo_count != 0). Pop = item_valid & item_ready.
- item_* outputs always reflect the FIFO head and remain stable while item_valid=1 and item_ready=0.

Latency and throughput:
- A beat accepted at edge N into an empty FIFO gives item_valid=1 in the cycle after edge N.
- Simultaneous push and pop keeps the count unchanged, so there is 1 beat/cycle steady-state throughput.
- When full, tready=0. A pop in that cycle does not admit a beat in the same cycle; tready rises the next cycle.
- When en=0, tready=0 but the FIFO keeps draining. en has no effect on the error checker.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. fifo_count is log2(FIFO_DEPTH)+1 bits wide.

Statistics:
- beat_count increments by 1 per accept.
- packet_count increments by 1 per accept with tlast=1.
- Both wrap from 0xFFFFFFFF to 0.

tlast checker (only when tlast_interval != 0; evaluated per accepted beat, pos = beat_idx + 1):
- tlast=1 and pos < tlast_interval: set early_tlast_err, beat_idx <= 0.
- tlast=0 and pos >= tlast_interval: set missing_tlast_err, beat_idx <= 0. This resynchronises to the interval.
- tlast=1 and pos == tlast_interval: correct end of packet, beat_idx <= 0.
- Otherwise: beat_idx <= pos.
- When tlast_interval == 0: no flags are set; beat_idx <= 0 on tlast, otherwise increments.
- A change of tlast_interval mid-packet takes effect from the next accepted beat. beat_idx is not cleared.

Error flags:
- Set and error_clear in the same cycle: set wins.
- error_clear alone clears both flags at the next edge.

Test Plan:
1. Reset, en=1, tlast_interval=4; send 8 back-to-back beats with pc=0x1000+i, instr=0x13+i, tlast on beats 4 and 8, item_ready=1 -> 8 items appear in order, each one cycle after its accept; item_last on items 4 and 8; beat_count=8; packet_count=2; no errors.
2. item_ready=0, FIFO_DEPTH=4, tvalid held high -> exactly 4 accepts, then tready=0. Raise item_ready for one cycle -> one pop, tready=1 on the next cycle, fifth beat accepted. Item order is preserved.
3. tlast_interval=4; tlast on beat 2 -> early_tlast_err=1, packet_count=1. The next 4-beat packet is clean, and the flag stays 1 until error_clear.
4. tlast_interval=3; 5 beats with no tlast -> missing_tlast_err=1 on beat 3, beat index restarts, and the flag stays sticky. Pulse error_clear in the same cycle as a new missing event -> the flag remains 1.
5. Mid-stream with 3 items buffered, en=0 -> tready=0 immediately; the 3 items drain. Assert rst_n=0 asynchronously mid-drain -> item_valid, counts and flags are 0 without waiting for a clock edge.
6. beat_count preloaded near wrap via force to 0xFFFFFFFE; send 3 beats -> beat_count=0x00000001.
